// File: rtl/multdiv_pkg.sv
// Shared types and default cycle budgets for the mult/div scheduler.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MULT = 2'd1,
    RUN_DIV  = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  localparam int MULT_CYCLES_DEF = 17;
  localparam int DIV_CYCLES_DEF  = 33;

endpackage

// File: rtl/multdiv_cycle_counter.sv
// Saturating up-counter with synchronous clear/enable and a terminal-count flag.
module multdiv_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  assign at_term = (count == terminal);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !at_term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// Issue/writeback sequencer for the shared multiplier and divider.
// Optional MULTDIV_FLUSH_EN adds a flush input that abandons the current op.
//
// state    | meaning
// IDLE     | no op in flight, issue accepted
// RUN_MULT | multiplier counting its cycle budget
// RUN_DIV  | divider counting its cycle budget
// DONE     | result held for writeback until wb_ack
module multdiv_scheduler
  import multdiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int TAG_W       = 5,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MULTDIV_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             issue_mult,
  input  logic             issue_div,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  output logic             stall,
  output logic             mult_start,
  output logic             div_start,
  input  logic [31:0]      mult_result,
  input  logic             mult_ovf,
  input  logic [31:0]      div_result,
  input  logic             div_by_zero,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             wb_exception,
  input  logic             wb_ack,
  output logic             busy_valid,
  output logic [TAG_W-1:0] busy_tag
);

  localparam logic [CNT_W-1:0] MULT_TERM = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_TERM  = CNT_W'(DIV_CYCLES);

  state_t           state, state_nxt;
  op_t              req_op;
  logic             req_any;
  logic             accept;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;
  logic             exc_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] terminal;
  logic             at_term;
  logic             running;

  assign running  = (state == RUN_MULT) || (state == RUN_DIV);
  assign terminal = (state == RUN_DIV) ? DIV_TERM : MULT_TERM;

  multdiv_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (!running),
    .enable   (running),
    .terminal (terminal),
    .count    (count),
    .at_term  (at_term)
  );

  // Multiply wins when both requests arrive together.
  assign req_any = issue_mult || issue_div;
  assign req_op  = issue_mult ? OP_MULT : OP_DIV;

  always_comb begin
    state_nxt   = state;
    issue_ready = 1'b0;
    mult_start  = 1'b0;
    div_start   = 1'b0;
    wb_valid    = 1'b0;
    busy_valid  = 1'b0;
    case (state)
      IDLE: begin
        issue_ready = 1'b1;
      end
      RUN_MULT: begin
        busy_valid = 1'b1;
        mult_start = (count == '0);
        if (at_term) state_nxt = DONE;
      end
      RUN_DIV: begin
        busy_valid = 1'b1;
        div_start  = (count == '0);
        if (at_term) state_nxt = DONE;
      end
      DONE: begin
        busy_valid = 1'b1;
        wb_valid   = 1'b1;
        if (wb_ack) begin
          issue_ready = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue_ready && req_any) begin
      state_nxt = (req_op == OP_MULT) ? RUN_MULT : RUN_DIV;
    end
`ifdef MULTDIV_FLUSH_EN
    if (flush && state != IDLE) begin
      issue_ready = 1'b0;
      state_nxt   = IDLE;
    end
`endif
  end

  assign accept       = issue_ready && req_any;
  assign stall        = req_any && !issue_ready;
  assign busy_tag     = tag_q;
  assign wb_tag       = wb_valid ? tag_q : '0;
  assign wb_data      = wb_valid ? data_q : '0;
  assign wb_exception = wb_valid && exc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tag_q  <= '0;
      data_q <= '0;
      exc_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) tag_q <= issue_tag;
      if (state == RUN_MULT && at_term) begin
        exc_q  <= mult_ovf;
        data_q <= mult_ovf ? 32'd0 : mult_result;
      end else if (state == RUN_DIV && at_term) begin
        exc_q  <= div_by_zero;
        data_q <= div_by_zero ? 32'd0 : div_result;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Self-checking bench for multdiv_scheduler: directed scenarios plus a randomized op stream.
module tb_multdiv_scheduler;
  localparam int MC = 17;
  localparam int DC = 33;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          issue_mult = 1'b0, issue_div = 1'b0;
  logic [TW-1:0] issue_tag = '0;
  logic          issue_ready, stall, mult_start, div_start;
  logic [31:0]   mult_result = '0, div_result = '0;
  logic          mult_ovf = 1'b0, div_by_zero = 1'b0;
  logic          wb_valid, wb_exception, busy_valid;
  logic [TW-1:0] wb_tag, busy_tag;
  logic [31:0]   wb_data;
  logic          wb_ack = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  multdiv_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .TAG_W(TW), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
`ifdef MULTDIV_FLUSH_EN
    .flush(flush),
`endif
    .issue_mult(issue_mult), .issue_div(issue_div), .issue_tag(issue_tag),
    .issue_ready(issue_ready), .stall(stall),
    .mult_start(mult_start), .div_start(div_start),
    .mult_result(mult_result), .mult_ovf(mult_ovf),
    .div_result(div_result), .div_by_zero(div_by_zero),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_exception(wb_exception), .wb_ack(wb_ack),
    .busy_valid(busy_valid), .busy_tag(busy_tag)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    issue_mult = 1'b0; issue_div = 1'b0; wb_ack = 1'b0; flush = 1'b0;
    tick; tick;
    reset = 1'b0;
    settle;
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    n_checks++;
    if ({stall, mult_start, div_start, wb_valid, busy_valid, wb_exception} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000000", {stall, mult_start, div_start, wb_valid, busy_valid, wb_exception});
    end
    n_checks++;
    if (wb_data !== 32'd0 || wb_tag !== '0 || busy_tag !== '0) begin
      n_fail++; $display("FAIL reset_data got data=%h tag=%0d btag=%0d exp=0", wb_data, wb_tag, busy_tag);
    end
    tick;
  endtask

  task automatic test_mult;
    mult_result = 32'h0000_00C8; mult_ovf = 1'b0;
    issue_mult = 1'b1; issue_tag = 5'd7;
    settle;
    n_checks++;
    if (issue_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL mult_accept got ready=%b stall=%b exp ready=1 stall=0", issue_ready, stall);
    end
    tick;
    issue_mult = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      wb_ack = (c == 24);
      settle;
      n_checks++;
      if (mult_start !== (c == 1) || div_start !== 1'b0) begin
        n_fail++; $display("FAIL mult_start_pulse cycle=%0d got=%b exp=%b", c, mult_start, c == 1);
      end
      n_checks++;
      if (wb_valid !== (c >= MC + 2)) begin
        n_fail++; $display("FAIL mult_wb_valid cycle=%0d got=%b exp=%b", c, wb_valid, c >= MC + 2);
      end
      n_checks++;
      if (busy_valid !== 1'b1 || busy_tag !== 5'd7) begin
        n_fail++; $display("FAIL mult_busy cycle=%0d got=%b/%0d exp=1/7", c, busy_valid, busy_tag);
      end
      if (c >= MC + 2) begin
        n_checks++;
        if (wb_tag !== 5'd7 || wb_data !== 32'hC8 || wb_exception !== 1'b0) begin
          n_fail++; $display("FAIL mult_wb_payload cycle=%0d got tag=%0d data=%h exc=%b exp 7/c8/0", c, wb_tag, wb_data, wb_exception);
        end
      end
      if (c == MC + 2) mult_result = $urandom;
      tick;
    end
    wb_ack = 1'b0;
    settle;
    n_checks++;
    if (wb_valid !== 1'b0 || busy_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL mult_release got valid=%b busy=%b ready=%b exp 0/0/1", wb_valid, busy_valid, issue_ready);
    end
    tick;
  endtask

  task automatic test_div_zero;
    div_result = 32'hDEAD_BEEF; div_by_zero = 1'b1;
    issue_div = 1'b1; issue_tag = 5'd3;
    settle;
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL div_accept got=%b exp=1", issue_ready); end
    tick;
    issue_div = 1'b0;
    for (int c = 1; c <= DC + 3; c++) begin
      wb_ack = (c == DC + 3);
      settle;
      n_checks++;
      if (div_start !== (c == 1) || mult_start !== 1'b0) begin
        n_fail++; $display("FAIL div_start_pulse cycle=%0d got=%b exp=%b", c, div_start, c == 1);
      end
      n_checks++;
      if (wb_valid !== (c >= DC + 2) || busy_valid !== 1'b1) begin
        n_fail++; $display("FAIL div_valid cycle=%0d got valid=%b busy=%b exp=%b/1", c, wb_valid, busy_valid, c >= DC + 2);
      end
      if (c >= DC + 2) begin
        n_checks++;
        if (wb_exception !== 1'b1 || wb_data !== 32'd0 || wb_tag !== 5'd3) begin
          n_fail++; $display("FAIL div_zero_payload got exc=%b data=%h tag=%0d exp 1/0/3", wb_exception, wb_data, wb_tag);
        end
      end
      tick;
    end
    div_by_zero = 1'b0;
    wb_ack = 1'b0;
    settle;
    n_checks++;
    if (busy_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL div_release got busy=%b ready=%b exp 0/1", busy_valid, issue_ready);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    mult_result = 32'h1234_5678; mult_ovf = 1'b0;
    div_result = 32'h0000_0042; div_by_zero = 1'b0;
    issue_mult = 1'b1; issue_div = 1'b1; issue_tag = 5'd9;
    settle;
    n_checks++;
    if (issue_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL both_accept got ready=%b stall=%b exp 1/0", issue_ready, stall);
    end
    tick;
    issue_mult = 1'b0; issue_tag = 5'd12;
    for (int c = 1; c <= MC + 2; c++) begin
      wb_ack = (c == MC + 2);
      settle;
      if (c < MC + 2) begin
        n_checks++;
        if (stall !== 1'b1 || div_start !== 1'b0) begin
          n_fail++; $display("FAIL div_stalled cycle=%0d got stall=%b dstart=%b exp 1/0", c, stall, div_start);
        end
      end else begin
        n_checks++;
        if (issue_ready !== 1'b1 || stall !== 1'b0 || wb_tag !== 5'd9 || wb_data !== 32'h1234_5678) begin
          n_fail++; $display("FAIL b2b_ack_cycle got ready=%b stall=%b tag=%0d data=%h exp 1/0/9/12345678", issue_ready, stall, wb_tag, wb_data);
        end
      end
      tick;
    end
    issue_div = 1'b0; wb_ack = 1'b0;
    for (int c = 1; c <= DC + 2; c++) begin
      settle;
      if (c == 1) begin
        n_checks++;
        if (div_start !== 1'b1 || busy_tag !== 5'd12 || busy_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_no_bubble got dstart=%b btag=%0d busy=%b exp 1/12/1", div_start, busy_tag, busy_valid);
        end
      end
      n_checks++;
      if (wb_valid !== (c == DC + 2)) begin
        n_fail++; $display("FAIL b2b_div_valid cycle=%0d got=%b exp=%b", c, wb_valid, c == DC + 2);
      end
      if (c == DC + 2) begin
        n_checks++;
        if (wb_data !== 32'h42 || wb_tag !== 5'd12) begin
          n_fail++; $display("FAIL b2b_div_payload got data=%h tag=%0d exp 42/12", wb_data, wb_tag);
        end
        wb_ack = 1'b1;
      end
      tick;
    end
    wb_ack = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    mult_result = 32'hCAFE_0001; mult_ovf = 1'b0;
    issue_mult = 1'b1; issue_tag = 5'd21;
    tick;
    issue_mult = 1'b0;
    for (int c = 1; c < MC + 2; c++) tick;
    issue_div = 1'b1; issue_tag = 5'd2;
    for (int h = 1; h <= 10; h++) begin
      mult_result = $urandom;
      settle;
      n_checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE_0001 || wb_tag !== 5'd21 || wb_exception !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold h=%0d got valid=%b data=%h tag=%0d exp 1/cafe0001/21", h, wb_valid, wb_data, wb_tag);
      end
      n_checks++;
      if (issue_ready !== 1'b0 || stall !== 1'b1) begin
        n_fail++; $display("FAIL bp_ready h=%0d got ready=%b stall=%b exp 0/1", h, issue_ready, stall);
      end
      tick;
    end
    issue_div = 1'b0; wb_ack = 1'b1;
    tick;
    wb_ack = 1'b0;
    settle;
    n_checks++;
    if (wb_valid !== 1'b0 || busy_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_to_idle got valid=%b busy=%b ready=%b exp 0/0/1", wb_valid, busy_valid, issue_ready);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    mult_result = 32'h5555_AAAA;
    issue_mult = 1'b1; issue_tag = 5'd17;
    tick;
    issue_mult = 1'b0;
    for (int c = 1; c < 10; c++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int c = 0; c < MC + 6; c++) begin
      settle;
      n_checks++;
      if (mult_start !== 1'b0 || wb_valid !== 1'b0 || busy_valid !== 1'b0 || issue_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_mid c=%0d got start=%b valid=%b busy=%b ready=%b exp 0/0/0/1", c, mult_start, wb_valid, busy_valid, issue_ready);
      end
      tick;
    end
  endtask

  // Reference: an accepted op reports in exactly N+2 cycles with data = exception ? 0 : result.
  task automatic test_random;
    bit          pending = 1'b0;
    bit          is_mult, exc;
    logic [TW-1:0] tag;
    logic [31:0] res;
    int          lat, hold;
    for (int op = 0; op < 8; op++) begin
      is_mult = 1'($urandom_range(0, 1));
      exc     = ($urandom_range(0, 3) == 0);
      tag     = TW'($urandom);
      res     = $urandom;
      lat     = is_mult ? MC + 2 : DC + 2;
      mult_result = is_mult ? res : $urandom;
      div_result  = is_mult ? $urandom : res;
      mult_ovf    = is_mult ? exc : 1'b1;
      div_by_zero = is_mult ? 1'b1 : exc;
      issue_mult = is_mult; issue_div = !is_mult; issue_tag = tag;
      wb_ack = pending;
      settle;
      n_checks++;
      if (issue_ready !== 1'b1 || stall !== 1'b0) begin
        n_fail++; $display("FAIL rnd_accept op=%0d got ready=%b stall=%b exp 1/0", op, issue_ready, stall);
      end
      tick;
      issue_mult = 1'b0; issue_div = 1'b0; wb_ack = 1'b0; issue_tag = TW'($urandom);
      for (int rel = 1; rel <= lat; rel++) begin
        settle;
        n_checks++;
        if (wb_valid !== (rel == lat) || busy_valid !== 1'b1 || busy_tag !== tag) begin
          n_fail++; $display("FAIL rnd_progress op=%0d rel=%0d got valid=%b busy=%b btag=%0d exp %b/1/%0d", op, rel, wb_valid, busy_valid, busy_tag, rel == lat, tag);
        end
        if (rel == 1) begin
          n_checks++;
          if (mult_start !== is_mult || div_start !== !is_mult) begin
            n_fail++; $display("FAIL rnd_start op=%0d got m=%b d=%b exp m=%b", op, mult_start, div_start, is_mult);
          end
        end
        tick;
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        settle;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_tag !== tag || wb_data !== (exc ? 32'd0 : res) || wb_exception !== exc) begin
          n_fail++; $display("FAIL rnd_payload op=%0d got tag=%0d data=%h exc=%b exp %0d/%h/%b", op, wb_tag, wb_data, wb_exception, tag, exc ? 32'd0 : res, exc);
        end
        if (h < hold) tick;
      end
      #1;
      if (op < 7 && $urandom_range(0, 1) == 1) begin
        pending = 1'b1;
        @(posedge clk); #1;
        pending = 1'b1;
      end else begin
        pending = 1'b0;
        @(posedge clk); #1;
        wb_ack = 1'b1;
        tick;
        wb_ack = 1'b0;
        settle;
        n_checks++;
        if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
          n_fail++; $display("FAIL rnd_release op=%0d got valid=%b ready=%b exp 0/1", op, wb_valid, issue_ready);
        end
        tick;
      end
    end
  endtask

`ifdef MULTDIV_FLUSH_EN
  task automatic test_flush;
    issue_mult = 1'b1; issue_tag = 5'd4;
    tick;
    issue_mult = 1'b0;
    for (int c = 1; c < 6; c++) tick;
    flush = 1'b1; issue_div = 1'b1; issue_tag = 5'd8;
    settle;
    n_checks++;
    if (issue_ready !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_issue got ready=%b stall=%b exp 0/1", issue_ready, stall);
    end
    tick;
    flush = 1'b0; issue_div = 1'b0;
    for (int c = 0; c < MC + 6; c++) begin
      settle;
      n_checks++;
      if (wb_valid !== 1'b0 || busy_valid !== 1'b0 || issue_ready !== 1'b1 || div_start !== 1'b0) begin
        n_fail++; $display("FAIL flush_idle c=%0d got valid=%b busy=%b ready=%b dstart=%b exp 0/0/1/0", c, wb_valid, busy_valid, issue_ready, div_start);
      end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_mult;
    test_div_zero;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_random;
`ifdef MULTDIV_FLUSH_EN
    test_flush;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
